memory_control: RTL

MEMORY_CONTROL -- requirements
Module: memory_control

---
 rtl/memory_control.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/memory_control.sv
// Arbitrates dcache and icache accesses onto a single RAM port.
// Three-state grant FSM with a fairness flag and saturating transfer counters.
module memory_control #(
   parameter int CTW = 16
) (
   input  logic           CLK,
   input  logic           nRST,
   input  logic           dREN,
   input  logic           dWEN,
   input  logic [31:0]    daddr,
   input  logic [31:0]    dstore,
   input  logic           iREN,
   input  logic [31:0]    iaddr,
   input  logic [31:0]    ramload,
   input  logic           ramready,
   output logic           dwait,
   output logic [31:0]    dload,
   output logic           iwait,
   output logic [31:0]    iload,
   output logic           ramREN,
   output logic           ramWEN,
   output logic [31:0]    ramaddr,
   output logic [31:0]    ramstore,
   output logic [CTW-1:0] dcount,
   output logic [CTW-1:0] icount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           ifair_q, ifair_d;
   logic [31:0]    daddr_q, daddr_d;
   logic [31:0]    dstore_q, dstore_d;
   logic           dwr_q, dwr_d;
   logic [31:0]    iaddr_q, iaddr_d;
   logic [CTW-1:0] dcount_q, dcount_d;
   logic [CTW-1:0] icount_q, icount_d;

   logic dgo, igo, ddone, idone;

   // A pending fairness turn lets the icache jump ahead of the dcache once.
   assign dgo   = (state_q == IDLE) && (dREN || dWEN) && !(ifair_q && iREN);
   assign igo   = (state_q == IDLE) && iREN && !dgo;
   assign ddone = (state_q == DACC) && ramready;
   assign idone = (state_q == IACC) && ramready;

   always_comb begin
      state_d  = state_q;
      ifair_d  = ifair_q;
      daddr_d  = daddr_q;
      dstore_d = dstore_q;
      dwr_d    = dwr_q;
      iaddr_d  = iaddr_q;
      dcount_d = dcount_q;
      icount_d = icount_q;
      unique case (state_q)
         IDLE: begin
            if (dgo) begin
               state_d  = DACC;
               daddr_d  = daddr;
               dstore_d = dstore;
               dwr_d    = dWEN;
            end else if (igo) begin
               state_d = IACC;
               iaddr_d = iaddr;
            end
         end
         DACC: begin
            if (ramready) begin
               state_d = IDLE;
               if (iREN) ifair_d = 1'b1;
            end
         end
         IACC: begin
            if (ramready) begin
               state_d = IDLE;
               ifair_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (ddone && (dcount_q != '1)) dcount_d = dcount_q + CTW'(1);
      if (idone && (icount_q != '1)) icount_d = icount_q + CTW'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         ifair_q  <= 1'b0;
         daddr_q  <= '0;
         dstore_q <= '0;
         dwr_q    <= 1'b0;
         iaddr_q  <= '0;
         dcount_q <= '0;
         icount_q <= '0;
      end else begin
         state_q  <= state_d;
         ifair_q  <= ifair_d;
         daddr_q  <= daddr_d;
         dstore_q <= dstore_d;
         dwr_q    <= dwr_d;
         iaddr_q  <= iaddr_d;
         dcount_q <= dcount_d;
         icount_q <= icount_d;
      end
   end

   // Completion strobes must track ramready in the same cycle.
   always_comb begin
      dwait    = 1'b1;
      iwait    = 1'b1;
      dload    = '0;
      iload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      unique case (state_q)
         DACC: begin
            ramaddr  = daddr_q;
            ramstore = dstore_q;
            ramWEN   = dwr_q;
            ramREN   = !dwr_q;
            if (ramready) begin
               dwait = 1'b0;
               dload = ramload;
            end
         end
         IACC: begin
            ramaddr = iaddr_q;
            ramREN  = 1'b1;
            if (ramready) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
         default: ;
      endcase
   end

   assign dcount = dcount_q;
   assign icount = icount_q;

endmodule
